// File: rtl/down_cnt_pkg.sv
// Shared encodings for the presettable down counter with borrow.
// Optional sticky overflow output is built in with DOWN_CNT_STICKY_EN.
package down_cnt_pkg;

    localparam int CNT_WIDTH = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_EXP  = 2'd2;

endpackage

// File: rtl/down_cnt_borrow_if.sv
// Control/status bundle for down_cnt_borrow.
// Carries ovf only when DOWN_CNT_STICKY_EN is defined.
interface down_cnt_borrow_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic             en;
    logic             auto;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             bo;
    logic             busy;
    logic             done;
`ifdef DOWN_CNT_STICKY_EN
    logic             ovf;
`endif

    modport master (
        output load, en, auto, d,
`ifdef DOWN_CNT_STICKY_EN
        input  ovf,
`endif
        input  q, bo, busy, done
    );

    modport slave (
        input  load, en, auto, d,
`ifdef DOWN_CNT_STICKY_EN
        output ovf,
`endif
        output q, bo, busy, done
    );

endinterface

// File: rtl/down_cnt_core.sv
// Count and reload registers with load/reload/decrement/hold selection.
// Built the same way with or without DOWN_CNT_STICKY_EN.
module down_cnt_core
    import down_cnt_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic             clk,
    input  logic             mr,
    input  logic             ld,
    input  logic             dec,
    input  logic             rld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             zero
);

    logic [WIDTH-1:0] rl;

    always_ff @(posedge clk or posedge mr) begin
        if (mr) begin
            q  <= '0;
            rl <= '0;
        end else if (ld) begin
            q  <= d;
            rl <= d;
        end else if (rld) begin
            q  <= rl;
        end else if (dec) begin
            q  <= q - WIDTH'(1);
        end
    end

    assign zero = (q == '0);

endmodule

// File: rtl/down_cnt_borrow.sv
// Down counter with registered borrow, one-shot or auto-reload.
// DOWN_CNT_STICKY_EN adds a sticky ovf flag set by every borrow.
module down_cnt_borrow
    import down_cnt_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input logic              clk,
    input logic              mr,
    down_cnt_borrow_if.slave bus
);

    logic [1:0] state;
    logic [1:0] state_n;
    logic       ld;
    logic       dec;
    logic       rld;
    logic       bo_n;
    logic       zero;
    logic       bo_q;

    assign ld = ~bus.load;

    down_cnt_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk (clk),
        .mr  (mr),
        .ld  (ld),
        .dec (dec),
        .rld (rld),
        .d   (bus.d),
        .q   (bus.q),
        .zero(zero)
    );

    always_comb begin
        state_n = state;
        dec     = 1'b0;
        rld     = 1'b0;
        bo_n    = 1'b0;
        if (ld) begin
            state_n = (bus.d != '0 || bus.auto) ? ST_RUN : ST_EXP;
        end else begin
            case (state)
                ST_IDLE: state_n = ST_IDLE;
                ST_RUN: begin
                    if (bus.en) begin
                        // Zero-crossing either reloads or stops; never wraps.
                        if (zero) begin
                            bo_n = 1'b1;
                            if (bus.auto) rld = 1'b1;
                            else          state_n = ST_EXP;
                        end else begin
                            dec = 1'b1;
                        end
                    end
                end
                ST_EXP:  state_n = ST_EXP;
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge mr) begin
        if (mr) begin
            state <= ST_IDLE;
            bo_q  <= 1'b0;
        end else begin
            state <= state_n;
            bo_q  <= bo_n;
        end
    end

`ifdef DOWN_CNT_STICKY_EN
    logic ovf_q;

    always_ff @(posedge clk or posedge mr) begin
        if (mr)        ovf_q <= 1'b0;
        else if (ld)   ovf_q <= 1'b0;
        else if (bo_n) ovf_q <= 1'b1;
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.bo   = bo_q;
    assign bus.busy = (state == ST_RUN);
    assign bus.done = (state == ST_EXP);

endmodule

// File: tb/tb_down_cnt_borrow.sv
// Bench for down_cnt_borrow: spec-level model plus directed vectors.
// Define DOWN_CNT_STICKY_EN to also exercise ovf.
module tb_down_cnt_borrow;

    localparam int W = 4;

    logic clk;
    logic mr;
    int   checks;
    int   errors;
    bit   chk_en;

    down_cnt_borrow_if #(.WIDTH(W)) bus ();

    down_cnt_borrow #(
        .WIDTH(W)
    ) dut (
        .clk(clk),
        .mr (mr),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: mode is 0 idle, 1 counting, 2 expired.
    int       m_mode;
    int       m_q;
    int       m_rl;
    bit       m_bo;
    bit       m_ovf;

    always @(posedge clk or posedge mr) begin
        if (mr) begin
            m_mode = 0; m_q = 0; m_rl = 0; m_bo = 0; m_ovf = 0;
        end else if (!bus.load) begin
            m_q   = int'(bus.d);
            m_rl  = int'(bus.d);
            m_bo  = 0;
            m_ovf = 0;
            m_mode = (bus.d != 0 || bus.auto) ? 1 : 2;
        end else if (m_mode == 1 && bus.en) begin
            if (m_q > 0) begin
                m_q  = m_q - 1;
                m_bo = 0;
            end else begin
                m_bo  = 1;
                m_ovf = 1;
                if (bus.auto) m_q = m_rl;
                else          m_mode = 2;
            end
        end else begin
            m_bo = 0;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("q", int'(bus.q), m_q);
            chk("bo", int'(bus.bo), int'(m_bo));
            chk("busy", int'(bus.busy), int'(m_mode == 1));
            chk("done", int'(bus.done), int'(m_mode == 2));
`ifdef DOWN_CNT_STICKY_EN
            chk("ovf", int'(bus.ovf), int'(m_ovf));
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        chk_en = 0;
        mr = 1'b1;
        bus.load = 1'b1;
        bus.en   = 1'b0;
        bus.auto = 1'b0;
        bus.d    = '0;
        cyc();
        cyc();
        mr = 1'b0;
        chk_en = 1;
        cyc();
        chk("rst_q", int'(bus.q), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);

        // Async reset mid-count
        bus.load = 1'b0; bus.d = 4'd5;
        cyc();
        bus.load = 1'b1;
        chk("t1_q5", int'(bus.q), 5);
        mr = 1'b1;
        #1;
        chk("t1_mr_q", int'(bus.q), 0);
        chk("t1_mr_bo", int'(bus.bo), 0);
        chk("t1_mr_busy", int'(bus.busy), 0);
        chk("t1_mr_done", int'(bus.done), 0);
        mr = 1'b0;
        bus.en = 1'b1;
        repeat (3) cyc();
        chk("t1_idle_q", int'(bus.q), 0);

        // One-shot from 3
        bus.auto = 1'b0; bus.load = 1'b0; bus.d = 4'd3;
        cyc();
        bus.load = 1'b1;
        chk("t2_q3", int'(bus.q), 3);
        for (int i = 2; i >= 0; i--) begin
            cyc();
            chk("t2_q", int'(bus.q), i);
            chk("t2_bo0", int'(bus.bo), 0);
        end
        cyc();
        chk("t2_bo", int'(bus.bo), 1);
        chk("t2_done", int'(bus.done), 1);
        chk("t2_qz", int'(bus.q), 0);
        cyc();
        chk("t2_bo_after", int'(bus.bo), 0);
        chk("t2_q_after", int'(bus.q), 0);
        cyc();

        // Auto-reload period 3
        bus.auto = 1'b1; bus.load = 1'b0; bus.d = 4'd2;
        cyc();
        bus.load = 1'b1;
        chk("t3_q2", int'(bus.q), 2);
        for (int k = 1; k <= 7; k++) begin
            cyc();
            chk("t3_q", int'(bus.q), 2 - (k % 3));
            chk("t3_bo", int'(bus.bo), int'(k % 3 == 0));
            chk("t3_busy", int'(bus.busy), 1);
        end
        chk("t4_q1", int'(bus.q), 1);

        // Load beats enable
        bus.load = 1'b0; bus.d = 4'd9;
        cyc();
        bus.load = 1'b1;
        chk("t4_q9", int'(bus.q), 9);
        chk("t4_bo", int'(bus.bo), 0);
        bus.en = 1'b0;
        repeat (4) begin
            cyc();
            chk("t4_hold", int'(bus.q), 9);
        end

        // Zero presets
        bus.auto = 1'b0; bus.load = 1'b0; bus.d = 4'd0;
        cyc();
        bus.load = 1'b1; bus.en = 1'b1;
        chk("t5_done", int'(bus.done), 1);
        chk("t5_bo", int'(bus.bo), 0);
        cyc();
        chk("t5_bo_exp", int'(bus.bo), 0);
        bus.auto = 1'b1; bus.load = 1'b0;
        cyc();
        bus.load = 1'b1;
        chk("t5_busy", int'(bus.busy), 1);
        chk("t5_bo_ld", int'(bus.bo), 0);
        repeat (3) begin
            cyc();
            chk("t5_bo_every", int'(bus.bo), 1);
            chk("t5_q0", int'(bus.q), 0);
        end

`ifdef DOWN_CNT_STICKY_EN
        bus.en = 1'b0;
        repeat (2) cyc();
        chk("t6_ovf_set", int'(bus.ovf), 1);
        bus.load = 1'b0; bus.d = 4'd4;
        cyc();
        bus.load = 1'b1;
        chk("t6_ovf_clr", int'(bus.ovf), 0);
        bus.en = 1'b1;
`endif

        // Drop auto while counting from rl=0: stops on next crossing
        bus.auto = 1'b1; bus.load = 1'b0; bus.d = 4'd0;
        cyc();
        bus.load = 1'b1; bus.auto = 1'b0;
        cyc();
        chk("t7_bo", int'(bus.bo), 1);
        chk("t7_done", int'(bus.done), 1);
        cyc();
        cyc();
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
